fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of the async FIFO among NREQ packet sources in the write clock domain.
//  Round-robin, packet-locked: once granted, a requester owns the port until its beat flagged last is written.
//  Throttles writes against the FIFO full flag; sits between the write-side sources and fifo_top.
// PARAMETERS
//  NREQ    4   number of requesters (2..8)
//  DATA_W  8   beat width; matches FIFO wr_data
//  CNT_W   16  width of each per-requester packet counter (stats build only)
// PORTS
//  wr_clk        in   1            write-domain clock
//  wr_rst        in   1            synchronous, active-high reset
//  req           in   NREQ         requester i has a valid beat on data[i]
//  last          in   NREQ         beat on data[i] is the final beat of its packet
//  data          in   NREQ*DATA_W  flattened beats; requester i at [i*DATA_W +: DATA_W]
//  full          in   1            FIFO full flag (wr_clk domain)
//  gnt           out  NREQ         one-hot current owner; all-zero when idle
//  ack           out  NREQ         beat of requester i written this cycle; source advances on it
//  fifo_wr_en    out  1            write strobe to the FIFO
//  fifo_wr_data  out  DATA_W       beat to the FIFO
//  busy          out  1            a packet is in progress
// BEHAVIOUR
//  - Reset: state=IDLE, gnt=0, ack=0, fifo_wr_en=0, busy=0, rr pointer=NREQ-1 (req[0] has top priority first).
//  - FSM states: IDLE, BUSY.
//  - IDLE: if |req, pick the first set req scanning from pointer+1 with wrap.
//    Register the pick as owner, gnt<=onehot(owner), busy<=1, go BUSY.
//    No write occurs in the arbitration cycle; grant-to-first-write latency is 1 cycle.
//  - BUSY: fifo_wr_en = req[owner] & ~full (combinational).
//    fifo_wr_data = data[owner]; ack = gnt & {NREQ{fifo_wr_en}}.
//  - BUSY, write with last[owner]: pointer<=owner, gnt<=0, busy<=0, go IDLE.
//    Re-arbitration happens next cycle, so a minimum 1-cycle bubble separates packets.
//  - BUSY, req[owner] low: hold ownership, no write, no timeout. Other requesters wait.
//  - full high: no write, no ack; ownership held. The write resumes the cycle full drops.
//  - Single-beat packet (req & last together): IDLE -> BUSY -> one write -> IDLE.
//  - last without a write (full or no req) has no effect.
//  - Requests from non-owners are ignored in BUSY. data/last of non-owners are don't-care.
//  - wr_rst mid-packet: the packet is abandoned and all state returns to reset values the next cycle.
//    The FIFO keeps the beats already written.
//  - fifo_wr_en never asserts while full=1 in the same cycle; the FIFO cannot overflow.
// CONFIGURATION
//  - FIFO_ARB_STATS_EN defined:
//    - Adds output pkt_cnt [NREQ*CNT_W], one counter per requester.
//    - A counter increments on each write with last for that requester; it wraps at 2^CNT_W. Reset clears it.
//  - FIFO_ARB_STATS_EN undefined: port and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Package fifo_arb_pkg: state enum (ARB_IDLE, ARB_BUSY) and default DATA_W/NREQ constants.
//  - Sub-module rr_picker: combinational rotate-priority encoder.
//    Inputs: req, pointer. Outputs: valid, index. Reused by the read-side distributor.
//  - The top holds the FSM, owner/pointer registers, data mux and the optional stats counters.
// TESTING
//  - Reset then req=4'b0101, 3-beat packets each:
//    -> gnt=0001 for 3 writes, 1 idle cycle, then gnt=0100. fifo_wr_data follows the source beats in order.
//  - All req high, 1-beat packets, 8 packets:
//    -> grant order 0,1,2,3,0,1,2,3; each packet takes 2 cycles.
//  - Owner 1 mid-packet, full raised for 5 cycles:
//    -> fifo_wr_en=0 and ack=0 for those cycles, gnt stays 0010, resumes at the same beat.
//  - Owner 2 drops req for 3 cycles while req[0]=1:
//    -> no writes, gnt stays 0100, req[0] is served only after owner 2's last beat.
//  - wr_rst pulsed after beat 2 of a 4-beat packet:
//    -> next cycle gnt=0, busy=0; the following arbitration selects req[0] first.
//  - With FIFO_ARB_STATS_EN, 3 packets from req 3:
//    -> pkt_cnt[3]=3, others 0. With CNT_W=2, 5 packets -> 1 (wrap).

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizes for the FIFO write-port arbiter.
// The FIFO_ARB_STATS_EN build adds per-requester packet counters in fifo_wr_arbiter.
package fifo_arb_pkg;

  localparam int unsigned ARB_NREQ   = 4;
  localparam int unsigned ARB_DATA_W = 8;
  localparam int unsigned ARB_CNT_W  = 16;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: first set req scanning from pointer+1 with wrap.
// Shared with the read-side distributor.
module rr_picker #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] pointer,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    valid  = 1'b0;
    index  = '0;
    w_cand = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_cand = IDX_W'((32'(pointer) + k) % NREQ);
      if (!valid && req[w_cand]) begin
        valid = 1'b1;
        index = w_cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter for the async FIFO write port, throttled by full.
// Define FIFO_ARB_STATS_EN to add the pkt_cnt per-requester packet counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ   = ARB_NREQ,
  parameter int unsigned DATA_W = ARB_DATA_W
`ifdef FIFO_ARB_STATS_EN
  ,
  parameter int unsigned CNT_W  = ARB_CNT_W
`endif
) (
  input  logic                   wr_clk,
  input  logic                   wr_rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        last,
  input  logic [NREQ*DATA_W-1:0] data,
  input  logic                   full,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic                   fifo_wr_en,
  output logic [DATA_W-1:0]      fifo_wr_data,
  output logic                   busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NREQ*CNT_W-1:0]  pkt_cnt
`endif
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_pick_valid;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_wr_en;
  logic             w_pkt_done;
  logic [DATA_W-1:0] w_wr_data;

  rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (req),
    .pointer (r_ptr),
    .valid   (w_pick_valid),
    .index   (w_pick_idx)
  );

  // State and ownership registers
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_state <= ARB_IDLE;
      r_owner <= '0;
      r_ptr   <= IDX_W'(NREQ - 1);
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Arbitration in IDLE; in BUSY the owner streams beats until its last one is written
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_busy_nxt  = r_busy;
    w_wr_en     = 1'b0;
    w_pkt_done  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_valid) begin
          w_owner_nxt = w_pick_idx;
          w_gnt_nxt   = NREQ'(1) << w_pick_idx;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        w_wr_en    = req[r_owner] & ~full;
        w_pkt_done = w_wr_en & last[r_owner];
        if (w_pkt_done) begin
          w_ptr_nxt   = r_owner;
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    w_wr_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_owner == IDX_W'(i)) w_wr_data = data[i*DATA_W +: DATA_W];
    end
  end

  assign gnt          = r_gnt;
  assign busy         = r_busy;
  assign fifo_wr_en   = w_wr_en;
  assign fifo_wr_data = w_wr_data;
  assign ack          = r_gnt & {NREQ{w_wr_en}};

`ifdef FIFO_ARB_STATS_EN
  logic [CNT_W-1:0] r_pkt_cnt [NREQ];

  // Completed packets per requester, wrapping
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      for (int unsigned i = 0; i < NREQ; i++) r_pkt_cnt[i] <= '0;
    end else if (w_pkt_done) begin
      r_pkt_cnt[r_owner] <= r_pkt_cnt[r_owner] + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign pkt_cnt[g*CNT_W +: CNT_W] = r_pkt_cnt[g];
  end
`endif

endmodule
